// File: rtl/multi_datapath_pkg.sv
// Shared encodings for the multicycle MIPS datapath: ALU ops, mux selects, opcodes.
package multi_datapath_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLL = 3'b011,
        ALU_SRL = 3'b100,
        ALU_SRA = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_REG_A = 2'b01,
        SRCA_SHAMT = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_e;

    typedef enum logic [2:0] {
        SRCB_REG_B     = 3'b000,
        SRCB_FOUR      = 3'b001,
        SRCB_IMM       = 3'b010,
        SRCB_BRANCH    = 3'b011,
        SRCB_REG_B_ALT = 3'b100
    } src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_REG_A  = 2'b11
    } pc_src_e;

    localparam logic [5:0]  OP_ANDI          = 6'b001100;
    localparam logic [5:0]  OP_ORI           = 6'b001101;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Logical immediates (andi/ori) zero-extend; everything else sign-extends.
    function automatic logic [31:0] imm_extend(input logic [31:0] ir);
        if (ir[31:26] == OP_ANDI || ir[31:26] == OP_ORI)
            return {16'h0000, ir[15:0]};
        return {{16{ir[15]}}, ir[15:0]};
    endfunction

endpackage

// File: rtl/multi_datapath_if.sv
// Control word, status and unified memory bus between control/memory and datapath.
interface multi_datapath_if;
    logic [1:0]  alu_src_a;
    logic [2:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic        instr_or_data;
    logic        instr_reg_we;
    logic        reg_we;
    logic        reg_write_addr;
    logic        reg_write_data;
    logic        pc_reg_we;
    logic [2:0]  alu_controller;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [5:0]  operation;
    logic [5:0]  func;
    logic        zero;

    modport master (
        output alu_src_a, alu_src_b, pc_src, instr_or_data, instr_reg_we, reg_we,
               reg_write_addr, reg_write_data, pc_reg_we, alu_controller, mem_rdata,
        input  mem_addr, mem_wdata, operation, func, zero
    );

    modport slave (
        input  alu_src_a, alu_src_b, pc_src, instr_or_data, instr_reg_we, reg_we,
               reg_write_addr, reg_write_data, pc_reg_we, alu_controller, mem_rdata,
        output mem_addr, mem_wdata, operation, func, zero
    );
endinterface

// File: rtl/multi_datapath_reg_file.sv
// 32x32 register file: two async read ports, one sync write port, r0 fixed at zero.
module multi_datapath_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Apply the pending write; writes aimed at r0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != 5'd0)
            regs_d[wr_addr] = wr_data;
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see pre-edge contents, so a same-cycle write is not bypassed.
    assign rd_data_a = (rd_addr_a == 5'd0) ? 32'h0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd0) ? 32'h0 : regs_q[rd_addr_b];

endmodule

// File: rtl/multi_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, register file, ALU and muxes.
module multi_datapath
    import multi_datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    multi_datapath_if.slave bus
);
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
    logic [31:0] src_a, src_b, alu_result, pc_next, imm_sext;
    logic [31:0] rs_data, rt_data, wr_data;
    logic [4:0]  wr_addr;

    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign wr_addr  = bus.reg_write_addr ? ir_q[15:11] : ir_q[20:16];
    assign wr_data  = bus.reg_write_data ? mdr_q : alu_out_q;

    multi_datapath_reg_file u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (ir_q[25:21]),
        .rd_addr_b (ir_q[20:16]),
        .rd_data_a (rs_data),
        .rd_data_b (rt_data),
        .wr_en     (bus.reg_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // ALU operand selection.
    always_comb begin
        case (bus.alu_src_a)
            SRCA_PC:    src_a = pc_q;
            SRCA_REG_A: src_a = a_q;
            SRCA_SHAMT: src_a = {27'd0, ir_q[10:6]};
            default:    src_a = 32'h0;
        endcase
        case (bus.alu_src_b)
            SRCB_REG_B, SRCB_REG_B_ALT: src_b = b_q;
            SRCB_FOUR:                  src_b = 32'd4;
            SRCB_IMM:                   src_b = imm_extend(ir_q);
            SRCB_BRANCH:                src_b = {imm_sext[29:0], 2'b00};
            default:                    src_b = 32'h0;
        endcase
    end

    // ALU; shifts move srcB by srcA[4:0].
    always_comb begin
        case (bus.alu_controller)
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SLL: alu_result = src_b << src_a[4:0];
            ALU_SRL: alu_result = src_b >> src_a[4:0];
            ALU_SRA: alu_result = $unsigned($signed(src_b) >>> src_a[4:0]);
            ALU_SUB: alu_result = src_a - src_b;
            default: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
        endcase
    end

    // Next-PC selection.
    always_comb begin
        case (bus.pc_src)
            PCSRC_ALU:    pc_next = alu_result;
            PCSRC_ALUOUT: pc_next = alu_out_q;
            PCSRC_JUMP:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
            default:      pc_next = a_q;
        endcase
    end

    // Next state of the architectural and pipeline-holding registers.
    always_comb begin
        pc_d      = bus.pc_reg_we ? pc_next : pc_q;
        ir_d      = bus.instr_reg_we ? bus.mem_rdata : ir_q;
        mdr_d     = bus.mem_rdata;
        a_d       = rs_data;
        b_d       = rt_data;
        alu_out_d = alu_result;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    assign bus.mem_addr  = bus.instr_or_data ? alu_out_q : pc_q;
    assign bus.mem_wdata = b_q;
    assign bus.operation = ir_q[31:26];
    assign bus.func      = ir_q[5:0];
    assign bus.zero      = (alu_result == 32'h0);

endmodule

// File: tb/tb_multi_datapath.sv
// Bench for multi_datapath: directed instruction sequences plus random control words,
// checked every cycle against an instruction-level model of the datapath.
module tb_multi_datapath;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;

    multi_datapath_if dp_if ();

    multi_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dp_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_out;
    logic [31:0] m_rf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_out = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    function automatic logic [31:0] m_alu();
        logic [31:0] sa, sb, sext;
        sext = {{16{m_ir[15]}}, m_ir[15:0]};
        case (dp_if.alu_src_a)
            2'd0: sa = m_pc;
            2'd1: sa = m_a;
            2'd2: sa = 32'(m_ir[10:6]);
            default: sa = 0;
        endcase
        case (dp_if.alu_src_b)
            3'd0, 3'd4: sb = m_b;
            3'd1: sb = 4;
            3'd2: sb = (m_ir[31:26] == 6'b001100 || m_ir[31:26] == 6'b001101)
                       ? 32'(m_ir[15:0]) : sext;
            3'd3: sb = sext * 4;
            default: sb = 0;
        endcase
        case (dp_if.alu_controller)
            3'd0: return sa & sb;
            3'd1: return sa | sb;
            3'd2: return sa + sb;
            3'd3: return sb << sa[4:0];
            3'd4: return sb >> sa[4:0];
            3'd5: return $signed(sb) >>> sa[4:0];
            3'd6: return sa - sb;
            default: return ($signed(sa) < $signed(sb)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // One clock edge of the machine, all updates from pre-edge values.
    task automatic model_step();
        logic [31:0] alu, npc, new_a, new_b;
        logic [4:0]  wa;
        if (rst) begin
            model_reset();
            return;
        end
        alu   = m_alu();
        new_a = m_rf[m_ir[25:21]];
        new_b = m_rf[m_ir[20:16]];
        case (dp_if.pc_src)
            2'd0: npc = alu;
            2'd1: npc = m_out;
            2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: npc = m_a;
        endcase
        wa = dp_if.reg_write_addr ? m_ir[15:11] : m_ir[20:16];
        if (dp_if.reg_we && wa != 0)
            m_rf[wa] = dp_if.reg_write_data ? m_mdr : m_out;
        if (dp_if.pc_reg_we) m_pc = npc;
        if (dp_if.instr_reg_we) m_ir = dp_if.mem_rdata;
        m_mdr = dp_if.mem_rdata;
        m_a   = new_a;
        m_b   = new_b;
        m_out = alu;
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_addr", dp_if.mem_addr, dp_if.instr_or_data ? m_out : m_pc);
            chk("mem_wdata", dp_if.mem_wdata, m_b);
            chk("operation", 32'(dp_if.operation), 32'(m_ir[31:26]));
            chk("func", 32'(dp_if.func), 32'(m_ir[5:0]));
            chk("zero", 32'(dp_if.zero), (m_alu() == 0) ? 32'd1 : 32'd0);
        end
    end

    task automatic idle_cw();
        dp_if.alu_src_a      = 2'd0;
        dp_if.alu_src_b      = 3'd0;
        dp_if.pc_src         = 2'd0;
        dp_if.instr_or_data  = 1'b0;
        dp_if.instr_reg_we   = 1'b0;
        dp_if.reg_we         = 1'b0;
        dp_if.reg_write_addr = 1'b0;
        dp_if.reg_write_data = 1'b0;
        dp_if.pc_reg_we      = 1'b0;
        dp_if.alu_controller = 3'd2;
        dp_if.mem_rdata      = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr);
        idle_cw();
        dp_if.alu_src_b    = 3'd1;
        dp_if.instr_reg_we = 1'b1;
        dp_if.pc_reg_we    = 1'b1;
        dp_if.mem_rdata    = instr;
        tick();
    endtask

    task automatic idle();
        idle_cw();
        tick();
    endtask

    task automatic exec(input logic [1:0] sa, input logic [2:0] sb, input logic [2:0] op);
        idle_cw();
        dp_if.alu_src_a      = sa;
        dp_if.alu_src_b      = sb;
        dp_if.alu_controller = op;
        tick();
    endtask

    task automatic wb(input logic rwa, input logic rwd);
        idle_cw();
        dp_if.reg_we         = 1'b1;
        dp_if.reg_write_addr = rwa;
        dp_if.reg_write_data = rwd;
        tick();
    endtask

    task automatic mem_rd(input logic [31:0] data, input logic [31:0] exp_addr);
        idle_cw();
        dp_if.instr_or_data = 1'b1;
        dp_if.mem_rdata     = data;
        #1;
        chk("lw_mem_addr", dp_if.mem_addr, exp_addr);
        tick();
    endtask

    task automatic pc_load(input logic [1:0] src);
        idle_cw();
        dp_if.pc_src    = src;
        dp_if.pc_reg_we = 1'b1;
        tick();
    endtask

    task automatic peek_out(input string name, input logic [31:0] exp);
        idle_cw();
        dp_if.instr_or_data = 1'b1;
        #1;
        chk(name, dp_if.mem_addr, exp);
    endtask

    task automatic peek_pc(input string name, input logic [31:0] exp);
        idle_cw();
        #1;
        chk(name, dp_if.mem_addr, exp);
    endtask

    task automatic load_word(input logic [31:0] instr, input logic [31:0] data);
        fetch(instr); idle(); exec(2'd1, 3'd2, 3'd2);
        mem_rd(data, 32'h108);
        wb(1'b0, 1'b1);
    endtask

    initial begin
        checks = 0; failures = 0; chk_en = 0;
        rst = 1'b0;
        idle_cw();
        model_reset();
        // Asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        chk("reset_mem_addr", dp_if.mem_addr, 32'h0);
        chk("reset_operation", 32'(dp_if.operation), 32'h0);
        chk("reset_func", 32'(dp_if.func), 32'h0);
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // addi $t0,$0,5
        fetch(32'h2008_0005);
        chk("fetch_operation", 32'(dp_if.operation), 32'h08);
        peek_pc("fetch_pc", 32'h4);
        idle(); exec(2'd1, 3'd2, 3'd2);
        peek_out("addi_aluout", 32'h5);
        wb(1'b0, 1'b0);
        // read $t0 back through A
        fetch(32'h0100_0000); idle(); exec(2'd1, 3'd7, 3'd2);
        peek_out("t0_readback", 32'h5);
        // addi $t1,$0,0x100 then lw $t2,8($t1)
        fetch(32'h2009_0100); idle(); exec(2'd1, 3'd2, 3'd2); wb(1'b0, 1'b0);
        load_word(32'h8D2A_0008, 32'hDEAD_BEEF);
        fetch(32'h0140_0000); idle(); exec(2'd1, 3'd7, 3'd2);
        peek_out("lw_readback", 32'hDEAD_BEEF);
        // andi with zero-extended 0xFFFF
        load_word(32'h8D2B_0008, 32'h1234_5678);
        fetch(32'h316C_FFFF); idle(); exec(2'd1, 3'd2, 3'd0);
        peek_out("andi_zext", 32'h0000_5678);
        // sll by 1
        load_word(32'h8D2D_0008, 32'h8000_0001);
        fetch(32'h000D_7040); idle(); exec(2'd2, 3'd0, 3'd3);
        peek_out("sll", 32'h0000_0002);
        // sra by 4
        load_word(32'h8D2F_0008, 32'h8000_0000);
        fetch(32'h000F_8103);
        chk("sra_func", 32'(dp_if.func), 32'h03);
        idle(); exec(2'd2, 3'd0, 3'd5);
        peek_out("sra", 32'hF800_0000);
        // write to r0 is discarded
        fetch(32'h0000_0000); idle(); exec(2'd0, 3'd1, 3'd2); wb(1'b1, 1'b0);
        idle(); idle(); exec(2'd1, 3'd7, 3'd1);
        peek_out("r0_stays_zero", 32'h0);
        // pc_src 11 from A = 0x40
        fetch(32'h2011_0040); idle(); exec(2'd1, 3'd2, 3'd2); wb(1'b0, 1'b0);
        fetch(32'h0220_0008); idle(); pc_load(2'd3);
        peek_pc("jr_pc", 32'h40);
        // pc_src 10 jump keeps PC[31:28]
        load_word(32'h8D32_0008, 32'h1000_0000);
        fetch(32'h0240_0008); idle(); pc_load(2'd3);
        fetch(32'h0800_0010);
        peek_pc("j_fetch_pc", 32'h1000_0004);
        pc_load(2'd2);
        peek_pc("jump_pc", 32'h1000_0040);

        // Reset mid-instruction, then restart at RESET_PC
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("midreset_mem_addr", dp_if.mem_addr, 32'h0);
        chk("midreset_operation", 32'(dp_if.operation), 32'h0);
        chk("midreset_func", 32'(dp_if.func), 32'h0);
        tick();
        rst = 1'b0;
        fetch(32'h2008_0005);
        peek_pc("restart_pc", 32'h4);

        // Random control words and memory data
        for (int n = 0; n < 3000; n++) begin
            dp_if.alu_src_a      = 2'($urandom);
            dp_if.alu_src_b      = 3'($urandom);
            dp_if.pc_src         = 2'($urandom);
            dp_if.instr_or_data  = 1'($urandom);
            dp_if.instr_reg_we   = ($urandom_range(0, 3) == 0);
            dp_if.reg_we         = 1'($urandom);
            dp_if.reg_write_addr = 1'($urandom);
            dp_if.reg_write_data = 1'($urandom);
            dp_if.pc_reg_we      = 1'($urandom);
            dp_if.alu_controller = 3'($urandom);
            dp_if.mem_rdata      = $urandom;
            tick();
        end

        idle_cw();
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
